// File: rtl/muldiv_pkg.sv
// Shared definitions for the MUL/DIV micro-step sequencer and its step counter.
package muldiv_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_ABRT = 3'd5
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_step_counter.sv
// 4-bit down-counter with load, decrement and zero flag; saturates at zero.
module muldiv_step_counter
    import muldiv_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Drives the T3..T6 bus strobes for MUL/DIV on the shared single-bus datapath.
//   state | meaning
//   IDLE  | waiting for start
//   T3    | Ra -> Y
//   T4    | Rb on bus, ALU settling, Z loaded on last cycle
//   T5    | Z[31:0] -> LO
//   T6    | Z[63:32] -> HI, done
//   ABRT  | one-cycle cancel acknowledge
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 1
) (
    input  logic       Clock,
    input  logic       Clear_n,
    input  logic       start,
    input  logic       op,
    input  logic [3:0] ra_sel,
    input  logic [3:0] rb_sel,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [3:0] reg_sel,
    output logic       Rout,
    output logic       Yin,
    output logic       alu_mul,
    output logic       alu_div,
    output logic       Zin,
    output logic       ZLOout,
    output logic       ZHIout,
    output logic       LOin,
    output logic       HIin,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_op;
    logic [3:0]       r_ra;
    logic [3:0]       r_rb;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;

    always @(posedge Clock) begin
        assert (MUL_CYCLES >= 1 && MUL_CYCLES <= 15 && DIV_CYCLES >= 1 && DIV_CYCLES <= 15)
            else $error("muldiv_sequencer: MUL_CYCLES/DIV_CYCLES must be in 1..15");
    end

    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operands are captured only on acceptance so later input changes are ignored.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            r_op <= OP_MUL;
            r_ra <= '0;
            r_rb <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_op <= op;
            r_ra <= ra_sel;
            r_rb <= rb_sel;
        end
    end

    assign w_cnt_load = (r_state == S_T3) && (w_next == S_T4);
    assign w_cnt_val  = (r_op == OP_DIV) ? DIV_LOAD : MUL_LOAD;

    muldiv_step_counter u_step_counter (
        .i_clk      (Clock),
        .i_rst_n    (Clear_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (r_state == S_T4),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_T3;
            S_T3:   w_next = abort ? S_ABRT : S_T4;
            S_T4: begin
                if (abort)           w_next = S_ABRT;
                else if (w_cnt_zero) w_next = S_T5;
                else                 w_next = S_T4;
            end
            S_T5:   w_next = S_T6;
            S_T6:   w_next = S_IDLE;
            S_ABRT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        aborted = 1'b0;
        reg_sel = '0;
        Rout    = 1'b0;
        Yin     = 1'b0;
        alu_mul = 1'b0;
        alu_div = 1'b0;
        Zin     = 1'b0;
        ZLOout  = 1'b0;
        ZHIout  = 1'b0;
        LOin    = 1'b0;
        HIin    = 1'b0;
        case (r_state)
            S_T3: begin
                busy    = 1'b1;
                reg_sel = r_ra;
                Rout    = 1'b1;
                Yin     = 1'b1;
            end
            S_T4: begin
                busy    = 1'b1;
                reg_sel = r_rb;
                Rout    = 1'b1;
                alu_mul = ~r_op;
                alu_div = r_op;
                Zin     = w_cnt_zero;
            end
            S_T5: begin
                busy   = 1'b1;
                ZLOout = 1'b1;
                LOin   = 1'b1;
            end
            S_T6: begin
                busy   = 1'b1;
                done   = 1'b1;
                ZHIout = 1'b1;
                HIin   = 1'b1;
            end
            S_ABRT:  aborted = 1'b1;
            default: ;
        endcase
    end

    assign state_o = r_state;

endmodule
